// File: rtl/timer_bcd_counter_pkg.sv
// Shared types and constants for the BCD stopwatch/countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0]  CSEC_MAX           = 8'h99;
    localparam logic [7:0]  SEC_MAX            = 8'h59;
    localparam int unsigned DEF_TICKS_PER_CSEC = 10;

    function automatic logic [7:0] to_bcd8(input int unsigned v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 10);
        ones = 4'(v % 10);
        return {tens, ones};
    endfunction

    // Non-BCD nibbles or over-range values saturate to the field maximum.
    function automatic logic [7:0] clamp_bcd(input logic [7:0] v, input logic [7:0] max_bcd);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max_bcd) begin
            return max_bcd;
        end
        return v;
    endfunction

endpackage

// File: rtl/timer_bcd_counter_digit_pair.sv
// Two-digit BCD up/down counter; cy_o flags the terminal value in the current direction.
module bcd_digit_pair (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       dir_i,
    input  logic [7:0] limit_i,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [7:0] val_o,
    output logic       cy_o
);

    logic [7:0] val_q, val_d;

    assign cy_o  = dir_i ? (val_q == 8'h00) : (val_q == limit_i);
    assign val_o = val_q;

    always_comb begin
        val_d = val_q;
        if (clr_i) begin
            val_d = '0;
        end else if (load_i) begin
            val_d = load_val_i;
        end else if (en_i) begin
            if (dir_i) begin
                if (cy_o)                    val_d = limit_i;
                else if (val_q[3:0] == 4'd0) val_d = {val_q[7:4] - 4'd1, 4'd9};
                else                         val_d = {val_q[7:4], val_q[3:0] - 4'd1};
            end else begin
                if (cy_o)                    val_d = '0;
                else if (val_q[3:0] == 4'd9) val_d = {val_q[7:4] + 4'd1, 4'd0};
                else                         val_d = {val_q[7:4], val_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) val_q <= '0;
        else         val_q <= val_d;
    end

endmodule

// File: rtl/timer_bcd_counter.sv
// MM:SS.cc stopwatch/countdown driven by an edge-detected 1 kHz data input.
module timer_bcd_counter
    import timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_CSEC = DEF_TICKS_PER_CSEC,
    parameter int unsigned MAX_MIN        = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_1khz,
    input  logic       start,
    input  logic       clear,
    input  logic       load,
    input  logic       mode_down,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] csec_bcd,
    output logic       running,
    output logic       done,
    output logic       done_pulse
);

    localparam int unsigned PW          = (TICKS_PER_CSEC > 1) ? $clog2(TICKS_PER_CSEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_CSEC - 1);
    localparam logic [7:0]  MIN_MAX     = to_bcd8(MAX_MIN);

    state_t        state_q, state_d;
    logic          mode_q, mode_d;
    logic          clk_1khz_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_pulse_q, done_pulse_d;

    logic       tick, csec_step, load_ok, step_en, sec_en, min_en;
    logic       cy_cs, cy_s, cy_m, all_term, at_one, val_zero, hit_end;
    logic [7:0] csec_v, sec_v, min_v;

    assign tick      = clk_1khz & ~clk_1khz_q;
    assign csec_step = (state_q == RUN) && tick && (presc_q == PRESC_MAX);
    assign load_ok   = load && !clear && (state_q == IDLE || state_q == PAUSE);

    // all_term: 59:59.99 going up, 00:00.00 going down; the step is suppressed there.
    assign all_term = cy_cs & cy_s & cy_m;
    assign at_one   = {min_v, sec_v, csec_v} == 24'h00_00_01;
    assign val_zero = {min_v, sec_v, csec_v} == 24'h00_00_00;
    assign hit_end  = csec_step && (all_term || (mode_q && at_one));
    assign step_en  = csec_step && !all_term;
    assign sec_en   = step_en && cy_cs;
    assign min_en   = sec_en && cy_s;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        if (state_q == RUN && tick) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        end
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
        end else if (load_ok) begin
            presc_d = '0;
        end else begin
            unique case (state_q)
                IDLE: if (start && !(mode_down && val_zero)) begin
                    state_d = RUN;
                    mode_d  = mode_down;
                    presc_d = '0;
                end
                RUN: begin
                    if (hit_end)    state_d = DONE;
                    else if (start) state_d = PAUSE;
                end
                PAUSE: if (start) state_d = RUN;
                DONE:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
        done_pulse_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            clk_1khz_q   <= 1'b0;
            presc_q      <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            clk_1khz_q   <= clk_1khz;
            presc_q      <= presc_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    bcd_digit_pair u_csec (
        .clk_i(clk), .rst_ni(rst_n), .en_i(step_en), .dir_i(mode_q), .limit_i(CSEC_MAX),
        .clr_i(clear), .load_i(load_ok), .load_val_i(8'h00), .val_o(csec_v), .cy_o(cy_cs)
    );

    bcd_digit_pair u_sec (
        .clk_i(clk), .rst_ni(rst_n), .en_i(sec_en), .dir_i(mode_q), .limit_i(SEC_MAX),
        .clr_i(clear), .load_i(load_ok), .load_val_i(clamp_bcd(load_sec, SEC_MAX)),
        .val_o(sec_v), .cy_o(cy_s)
    );

    bcd_digit_pair u_min (
        .clk_i(clk), .rst_ni(rst_n), .en_i(min_en), .dir_i(mode_q), .limit_i(MIN_MAX),
        .clr_i(clear), .load_i(load_ok), .load_val_i(clamp_bcd(load_min, MIN_MAX)),
        .val_o(min_v), .cy_o(cy_m)
    );

    assign min_bcd    = min_v;
    assign sec_bcd    = sec_v;
    assign csec_bcd   = csec_v;
    assign running    = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign done_pulse = done_pulse_q;

endmodule

// File: doc/timer_bcd_counter.md
Name: timer_bcd_counter

Overview:
- Consumes the 1 kHz square wave from the 1 kHz clock divider and runs a stopwatch/countdown in BCD MM:SS.cc.
- Counts up (stopwatch) or down (countdown) under start/pause/clear/load controls.
- Outputs BCD digit bytes to the display scanner and a done indication.
- Everything runs on the system clock. clk_1khz is used only as a data input and edge-detected; it never clocks a flop.

Parameters:
- TICKS_PER_CSEC, 10, number of clk_1khz rising edges per centisecond.
- MAX_MIN, 59, maximum minutes value, in binary.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  asynchronous active-low reset
- clk_1khz  in  1  1 kHz square wave from the divider, synchronous to clk
- start  in  1  one-cycle pulse; toggles run/pause
- clear  in  1  one-cycle pulse; return to IDLE with value zero
- load  in  1  one-cycle pulse; load preset value
- mode_down  in  1  0 = count up, 1 = count down; sampled on IDLE->RUN
- load_min  in  8  BCD minutes preset
- load_sec  in  8  BCD seconds preset
- min_bcd  out  8  BCD minutes
- sec_bcd  out  8  BCD seconds
- csec_bcd  out  8  BCD centiseconds
- running  out  1  high in RUN
- done  out  1  level, high in DONE
- done_pulse  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0. State IDLE. Prescaler 0. Edge register 0. Latched mode 0.
- Tick generation:
  - tick = clk_1khz & ~clk_1khz_q, using one register stage.
  - tick is high for one cycle, in the cycle after a rising edge of clk_1khz is seen.
- Prescaler:
  - Counts 0..TICKS_PER_CSEC-1 on tick, only in RUN.
  - Wraps to 0 and issues csec_step for one cycle.
  - Held, not cleared, in PAUSE, so resume continues the partial centisecond.
  - Cleared by clear, by load, and on IDLE->RUN.
- BCD arithmetic, on csec_step:
  - Up mode: csec 00..99 carries into sec; sec 00..59 carries into min; min 00..MAX_MIN.
  - Down mode: borrow in the reverse direction; csec 00 borrows to 99, sec 00 borrows to 59.
  - Every digit stays valid BCD at all times. Output registers update one cycle after csec_step.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE, start: go to RUN and latch mode_down. Exception: mode_down=1 with value 00:00.00, where start is ignored and state stays IDLE.
  - RUN, start: go to PAUSE.
  - PAUSE, start: go to RUN. Latched mode is unchanged.
  - RUN, up mode, csec_step while value = MAX_MIN:59.99: hold the value, go to DONE.
  - RUN, down mode, csec_step that yields 00:00.00: go to DONE.
  - DONE: start and load are ignored; only clear leaves DONE.
  - Any state, clear: go to IDLE, value 00:00.00, prescaler 0.
- Load:
  - Accepted in IDLE and PAUSE; ignored in RUN and DONE.
  - Sets min=load_min, sec=load_sec, csec=00.
  - Any nibble >9, or a field value above its maximum (sec >59, min >MAX_MIN), clamps that field to its maximum.
- Simultaneous events:
  - Priority is clear > load > start.
  - A start pulse in the same cycle as csec_step is applied after the step: the counter advances, then pauses.
- done_pulse:
  - Asserted for exactly one cycle, in the same cycle done rises.
- mode_down changes during RUN/PAUSE have no effect.
- rst_n asserted mid-count aborts immediately to the reset state.

Decomposition:
- Package timer_pkg:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - BCD limit constants (csec 99, sec 59).
  - Default TICKS_PER_CSEC.
- One sub-module, bcd_digit_pair: two-digit BCD up/down counter.
  - Inputs: en, dir, limit, load value.
  - Output: carry/borrow.
  - Instantiated three times for csec, sec and min, chained on carry/borrow.

Test Plan:
1. Reset, then clk_1khz toggling (bench period shortened to 20 clk cycles).
   - Before any start: outputs 00:00.00, running=0, done=0, no change over 500 ticks.
2. Up mode: start, then 10 ticks, then 990 more ticks.
   - csec_bcd=0x01 after 10 ticks.
   - After 1000 ticks total: 00:01.00, sec carry verified.
3. load_min=0x00, load_sec=0x01, mode_down=1, load, start, 1000 ticks.
   - Value decrements 00:00.99 ... 00:00.00.
   - done=1, done_pulse high for exactly 1 cycle, running=0.
4. Pause/resume: run 15 ticks, start (pause), 100 ticks, start (resume), 5 ticks.
   - csec_bcd=0x02 (prescaler retained), no advance during pause.
5. load_min=0x7A, load_sec=0x65 in IDLE.
   - min_bcd=0x59, sec_bcd=0x59.
   - load during RUN leaves the value unchanged.
6. Simultaneous clear+load+start in PAUSE.
   - Result: IDLE, 00:00.00.
   - Up mode from 59:59.99 plus one csec_step: holds 59:59.99, done=1.
   - Then rst_n low mid-RUN: all outputs 0 asynchronously.
